// File: rtl/butterfly_controller.sv
// Button-driven sequencer for the butterfly datapath. It debounces the pushbutton, walks
// through operand entry, runs a 4-cycle multiply burst, then steps the results to the display.
module butterfly_controller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       load_coeff,
  output logic       load_b,
  output logic       load_mult,
  output logic       multiply,
  output logic       load_output_reg,
  output logic       subtract,
  output logic       mult_out_select,
  output logic       fbr_input,
  output logic [3:0] step,
  output logic       busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [3:0] {
    W_REW = 4'd0,  W_IMW = 4'd1,  W_REB = 4'd2,  W_IMB = 4'd3,
    C_M0  = 4'd4,  C_X0  = 4'd5,  C_M1  = 4'd6,  C_X1  = 4'd7,
    W_REA = 4'd8,  W_IMA = 4'd9,  D_REY = 4'd10, D_IMY = 4'd11,
    D_REZ = 4'd12, D_IMZ = 4'd13
  } state_t;

  logic             sync_p0, sync_p1;
  logic             deb;
  logic [CNT_W-1:0] cnt;
  logic             press;
  state_t           state;

  // Button path: 2-flop synchroniser, stability counter, rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb     <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb   <= ~deb;
        cnt   <= '0;
        press <= ~deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sequencer: strobes are registered and live only for the cycle after their trigger
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= W_REW;
      load_coeff      <= 1'b0;
      load_b          <= 1'b0;
      load_mult       <= 1'b0;
      multiply        <= 1'b0;
      load_output_reg <= 1'b0;
      subtract        <= 1'b0;
      mult_out_select <= 1'b0;
      fbr_input       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      load_coeff      <= 1'b0;
      load_b          <= 1'b0;
      load_mult       <= 1'b0;
      multiply        <= 1'b0;
      load_output_reg <= 1'b0;
      subtract        <= 1'b0;
      mult_out_select <= 1'b0;
      fbr_input       <= 1'b0;
      busy            <= 1'b0;
      case (state)
        W_REW: if (press) begin load_coeff <= 1'b1; state <= W_IMW; end
        W_IMW: if (press) begin load_coeff <= 1'b1; state <= W_REB; end
        W_REB: if (press) begin load_b <= 1'b1; state <= W_IMB; end
        W_IMB: if (press) begin load_b <= 1'b1; busy <= 1'b1; state <= C_M0; end
        C_M0: begin
          load_b    <= 1'b1;
          load_mult <= 1'b1;
          subtract  <= 1'b1;
          busy      <= 1'b1;
          state     <= C_X0;
        end
        C_X0: begin
          multiply <= 1'b1;
          subtract <= 1'b1;
          busy     <= 1'b1;
          state    <= C_M1;
        end
        C_M1: begin
          load_mult <= 1'b1;
          busy      <= 1'b1;
          state     <= C_X1;
        end
        C_X1: begin
          multiply <= 1'b1;
          state    <= W_REA;
        end
        W_REA: if (press) begin load_output_reg <= 1'b1; fbr_input <= 1'b1; state <= W_IMA; end
        W_IMA: if (press) begin load_output_reg <= 1'b1; state <= D_REY; end
        D_REY: if (press) begin load_output_reg <= 1'b1; mult_out_select <= 1'b1; state <= D_IMY; end
        D_IMY: if (press) begin load_output_reg <= 1'b1; subtract <= 1'b1; state <= D_REZ; end
        D_REZ: if (press) begin
          load_output_reg <= 1'b1;
          subtract        <= 1'b1;
          mult_out_select <= 1'b1;
          state           <= D_IMZ;
        end
        D_IMZ: if (press) state <= W_REW;
        default: state <= W_REW;
      endcase
    end
  end

  assign step = state;

endmodule

// File: tb/tb_butterfly_controller.sv
// Directed bench for butterfly_controller: expected strobe patterns are queued as presses
// are driven and matched against every non-idle output cycle.
module tb_butterfly_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       load_coeff, load_b, load_mult, multiply, load_output_reg;
  logic       subtract, mult_out_select, fbr_input, busy;
  logic [3:0] step;

  localparam logic [7:0] LC = 8'h80, LB = 8'h40, LM = 8'h20, MU = 8'h10;
  localparam logic [7:0] LO = 8'h08, SU = 8'h04, MS = 8'h02, FB = 8'h01;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int busy_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] strobes;

  butterfly_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .load_coeff(load_coeff), .load_b(load_b), .load_mult(load_mult),
    .multiply(multiply), .load_output_reg(load_output_reg), .subtract(subtract),
    .mult_out_select(mult_out_select), .fbr_input(fbr_input),
    .step(step), .busy(busy)
  );

  always #5 clk = ~clk;

  assign strobes = {load_coeff, load_b, load_mult, multiply,
                    load_output_reg, subtract, mult_out_select, fbr_input};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle with any strobe high must match the oldest queued pattern
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (strobes != 8'h00) begin
      pulses++;
      if (exp_q.size() == 0) check("unexpected_strobe", {24'h0, strobes}, 32'h0);
      else check("strobe_pattern", {24'h0, strobes}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic press_btn(input int hold);
    btn = 1'b1;
    repeat (hold) @(posedge clk);
    btn = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // Raise btn and wait (bounded) for the cycle showing load_b alone
  task automatic wait_load_b(output bit ok);
    ok = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (strobes == LB) begin ok = 1'b1; break; end
    end
    check("load_b_seen", {31'h0, ok}, 32'h1);
  endtask

  initial begin
    bit ok;
    int p0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {24'h0, strobes}, 32'h0);
    check("reset_step", {28'h0, step}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;

    repeat (100) @(posedge clk);
    @(negedge clk);
    check("idle_step", {28'h0, step}, 32'h0);
    check("idle_pulses", pulses, 32'h0);

    btn = 1'b1;
    repeat (2) @(posedge clk);
    btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_step", {28'h0, step}, 32'h0);
    check("glitch_pulses", pulses, 32'h0);

    exp_q.push_back(LC);
    press_btn(60);
    @(negedge clk);
    check("first_press_step", {28'h0, step}, 32'h1);
    check("first_press_pulses", pulses, 32'h1);

    exp_q.push_back(LC);
    press_btn(10);
    exp_q.push_back(LB);
    press_btn(10);
    check("entry_step", {28'h0, step}, 32'h3);

    exp_q.push_back(LB);
    exp_q.push_back(LB | LM | SU);
    exp_q.push_back(MU | SU);
    exp_q.push_back(LM);
    exp_q.push_back(MU);
    busy_cycles = 0;
    p0 = pulses;
    wait_load_b(ok);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) force dut.press = 1'b1;
      if (i == 2) release dut.press;
      check("burst_consecutive", {31'h0, strobes != 8'h00}, 32'h1);
    end
    btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("burst_busy_cycles", busy_cycles, 32'd4);
    check("burst_rest_step", {28'h0, step}, 32'd8);
    check("burst_pulse_count", pulses - p0, 32'd5);

    exp_q.push_back(LO | FB);
    exp_q.push_back(LO);
    exp_q.push_back(LO | MS);
    exp_q.push_back(LO | SU);
    exp_q.push_back(LO | SU | MS);
    p0 = pulses;
    for (int i = 0; i < 6; i++) press_btn(10);
    check("display_pulse_count", pulses - p0, 32'd5);
    check("wrap_step", {28'h0, step}, 32'h0);

    exp_q.push_back(LC);
    press_btn(10);
    check("seventh_press_step", {28'h0, step}, 32'h1);

    exp_q.push_back(LC);
    press_btn(10);
    exp_q.push_back(LB);
    press_btn(10);
    exp_q.push_back(LB);
    exp_q.push_back(LB | LM | SU);
    wait_load_b(ok);
    @(negedge clk);
    check("in_c_x0_step", {28'h0, step}, 32'd5);
    btn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midburst_reset_strobes", {24'h0, strobes}, 32'h0);
    check("midburst_reset_step", {28'h0, step}, 32'h0);
    check("midburst_reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    exp_q.push_back(LC);
    press_btn(10);
    check("after_reset_step", {28'h0, step}, 32'h1);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
